// File: rtl/fft_frame_sequencer.sv
// Frames the 24-bit sample stream into 16-sample blocks, launches FFT_Processor and latches its bins.
// Optional watchdog on the done handshake is built when FFT_TIMEOUT_EN is defined.
module fft_frame_sequencer #(
  parameter int N_PTS  = 16,
  parameter int SAMP_W = 24,
  parameter int BIN_W  = 16
`ifdef FFT_TIMEOUT_EN
  , parameter int TIMEOUT = 64
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SAMP_W-1:0]       sample_in,
  input  logic                    sample_valid,
  output logic                    fft_new_t,
  output logic [N_PTS*SAMP_W-1:0] fft_t_bus,
  input  logic                    fft_done,
  input  logic [N_PTS*BIN_W-1:0]  fft_f_bus,
  output logic [N_PTS*BIN_W-1:0]  bins_out,
  output logic                    bins_valid,
  output logic                    busy,
  output logic [7:0]              drop_cnt,
  output logic                    timeout_err
);

  localparam int CNT_W = $clog2(N_PTS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_CAPTURE
  } state_t;

  state_t                    state_reg, state_next;
  logic [CNT_W-1:0]          fill_cnt_reg;
  logic [SAMP_W-1:0]         samp_buf_reg [N_PTS-1];
  logic [N_PTS*SAMP_W-1:0]   t_bus_reg;
  logic [N_PTS*BIN_W-1:0]    bins_reg;
  logic [7:0]                drop_cnt_reg;
  logic                      done_prev_reg;
  logic                      frame_full;
  logic                      done_rise;
  logic                      load_frame;
  logic                      capture_bins;
  logic                      drop_frame;
  logic [N_PTS*SAMP_W-1:0]   frame_flat;

  assign frame_full = sample_valid && (fill_cnt_reg == CNT_W'(N_PTS-1));
  assign done_rise  = fft_done && !done_prev_reg;

  // The last sample is never stored: it is forwarded straight into the frozen frame.
  genvar gi;
  generate
    for (gi = 0; gi < N_PTS; gi++) begin : g_frame
      if (gi == N_PTS-1) begin : g_last
        assign frame_flat[gi*SAMP_W +: SAMP_W] = sample_in;
      end else begin : g_buf
        assign frame_flat[gi*SAMP_W +: SAMP_W] = samp_buf_reg[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill_cnt_reg <= '0;
      for (int i = 0; i < N_PTS-1; i++) begin
        samp_buf_reg[i] <= '0;
      end
    end else if (sample_valid) begin
      if (frame_full) begin
        fill_cnt_reg <= '0;
      end else begin
        fill_cnt_reg               <= fill_cnt_reg + CNT_W'(1);
        samp_buf_reg[fill_cnt_reg] <= sample_in;
      end
    end
  end

`ifdef FFT_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT+1);
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic              timeout_err_reg;
  logic              timeout_fire;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    load_frame   = 1'b0;
    capture_bins = 1'b0;
    drop_frame   = 1'b0;
`ifdef FFT_TIMEOUT_EN
    timeout_fire = 1'b0;
`endif
    case (state_reg)
      S_IDLE: begin
        if (frame_full) begin
          load_frame = 1'b1;
          state_next = S_LAUNCH;
        end
      end
      S_LAUNCH: state_next = S_WAIT;
      S_WAIT: begin
        if (done_rise) begin
          capture_bins = 1'b1;
          state_next   = S_CAPTURE;
        end
`ifdef FFT_TIMEOUT_EN
        else if (wait_cnt_reg == WAIT_W'(TIMEOUT-1)) begin
          timeout_fire = 1'b1;
          state_next   = S_IDLE;
        end
`endif
      end
      S_CAPTURE: state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
    if (frame_full && (state_reg != S_IDLE)) begin
      drop_frame = 1'b1;
    end
  end

  // bins_reg loads on the WAIT->CAPTURE edge so bins_out is already new while bins_valid is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      t_bus_reg     <= '0;
      bins_reg      <= '0;
      drop_cnt_reg  <= '0;
      done_prev_reg <= 1'b0;
    end else begin
      if (load_frame) begin
        t_bus_reg <= frame_flat;
      end
      if (capture_bins) begin
        bins_reg <= fft_f_bus;
      end
      if (drop_frame && (drop_cnt_reg != 8'hFF)) begin
        drop_cnt_reg <= drop_cnt_reg + 8'd1;
      end
      if ((state_reg == S_LAUNCH) || (state_reg == S_WAIT)) begin
        done_prev_reg <= fft_done;
      end
    end
  end

`ifdef FFT_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_reg    <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      if (state_reg == S_WAIT) begin
        wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
      end else begin
        wait_cnt_reg <= '0;
      end
      if (timeout_fire) begin
        timeout_err_reg <= 1'b1;
      end
    end
  end

  assign timeout_err = timeout_err_reg;
`else
  assign timeout_err = 1'b0;
`endif

  assign fft_new_t  = (state_reg == S_LAUNCH);
  assign bins_valid = (state_reg == S_CAPTURE);
  assign busy       = (state_reg != S_IDLE);
  assign fft_t_bus  = t_bus_reg;
  assign bins_out   = bins_reg;
  assign drop_cnt   = drop_cnt_reg;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer: expected frames/bins are queued as stimulus is driven
// and popped when the DUT raises fft_new_t / bins_valid.
module tb_fft_frame_sequencer;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [23:0]  sample_in = '0;
  logic         sample_valid = 1'b0;
  logic         fft_new_t;
  logic [383:0] fft_t_bus;
  logic         fft_done = 1'b0;
  logic [255:0] fft_f_bus = '0;
  logic [255:0] bins_out;
  logic         bins_valid;
  logic         busy;
  logic [7:0]   drop_cnt;
  logic         timeout_err;

  fft_frame_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .fft_new_t    (fft_new_t),
    .fft_t_bus    (fft_t_bus),
    .fft_done     (fft_done),
    .fft_f_bus    (fft_f_bus),
    .bins_out     (bins_out),
    .bins_valid   (bins_valid),
    .busy         (busy),
    .drop_cnt     (drop_cnt),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [383:0] val;
    int           due;
  } frame_exp_t;

  typedef struct {
    logic [255:0] val;
    int           due;
  } bins_exp_t;

  frame_exp_t   frame_q[$];
  bins_exp_t    bins_q[$];
  int           checks = 0;
  int           errors = 0;
  int           tick_no = 0;
  int           model_fill = 0;
  int           done_cd = 0;
  int           newt_seen = 0;
  int           bv_seen = 0;
  bit           auto_done = 1'b0;
  logic [383:0] model_frame = '0;
  logic [255:0] last_bins = '0;
  logic [255:0] next_bins = '0;
  logic [255:0] bins_b = '0;

  task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    frame_exp_t fe;
    bins_exp_t  be;
    if (fft_new_t === 1'b1) begin
      newt_seen++;
      chk("new_t_expected", 384'(frame_q.size() != 0), 384'(1));
      if (frame_q.size() != 0) begin
        fe = frame_q.pop_front();
        chk("new_t_latency", 384'(tick_no), 384'(fe.due));
        chk("t_bus", fft_t_bus, fe.val);
      end
      if (auto_done) done_cd = 10;
    end
    if (bins_valid === 1'b1) begin
      bv_seen++;
      chk("bins_expected", 384'(bins_q.size() != 0), 384'(1));
      if (bins_q.size() != 0) begin
        be = bins_q.pop_front();
        chk("bins_latency", 384'(tick_no), 384'(be.due));
        chk("bins_out", bins_out, be.val);
      end
      last_bins = bins_out;
      if (auto_done) fft_done = 1'b0;
    end else begin
      chk("bins_hold", bins_out, last_bins);
    end
  endtask

  // One clock: outputs sampled on the falling edge, then the done model drives its inputs.
  task automatic tick();
    @(negedge clk);
    tick_no++;
    monitor();
    if (auto_done && done_cd > 0) begin
      done_cd--;
      if (done_cd == 0) begin
        fft_done  = 1'b1;
        fft_f_bus = next_bins;
        bins_q.push_back('{val: next_bins, due: tick_no + 1});
      end
    end
  endtask

  task automatic send_sample(input logic [23:0] v, input bit launch);
    model_frame[model_fill*24 +: 24] = v;
    if (model_fill == 15) begin
      if (launch) frame_q.push_back('{val: model_frame, due: tick_no + 1});
      model_fill = 0;
    end else begin
      model_fill++;
    end
    sample_in    = v;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    bit settled;
    settled = 1'b0;
    while (n < budget && !settled) begin
      tick();
      n++;
      settled = (busy === 1'b0) && (frame_q.size() == 0) && (bins_q.size() == 0) && (done_cd == 0);
    end
    chk(tag, 384'(settled), 384'(1));
  endtask

  task automatic release_done(input logic [255:0] b);
    fft_done  = 1'b1;
    fft_f_bus = b;
    bins_q.push_back('{val: b, due: tick_no + 1});
    tick();
    fft_done = 1'b0;
  endtask

  task automatic apply_reset();
    reset      = 1'b0;
    frame_q.delete();
    bins_q.delete();
    model_fill = 0;
    done_cd    = 0;
    last_bins  = '0;
    fft_done   = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bv0;
    // Reset state
    tick();
    tick();
    chk("rst_new_t", fft_new_t, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_bins_valid", bins_valid, 0);
    chk("rst_bins_out", bins_out, 0);
    chk("rst_t_bus", fft_t_bus, 0);
    chk("rst_timeout_err", timeout_err, 0);
    reset = 1'b1;
    tick();

    // Framing and done handshake: samples 1..16, done 10 cycles after new_t
    auto_done = 1'b1;
    for (int i = 0; i < 16; i++) next_bins[i*16 +: 16] = 16'(i + 1);
    for (int i = 1; i <= 15; i++) send_sample(24'(i), 1'b0);
    repeat (3) tick();
    chk("no_launch_after_15", 32'(newt_seen), 0);
    chk("idle_after_15", busy, 0);
    send_sample(24'd16, 1'b1);
    chk("launch_new_t", fft_new_t, 1);
    chk("launch_t0", fft_t_bus[23:0], 1);
    chk("launch_t15", fft_t_bus[383:360], 16);
    tick();
    chk("new_t_single_pulse", fft_new_t, 0);
    chk("busy_in_wait", busy, 1);
    wait_idle(40, "frame1_settled");
    chk("frame1_bins_valid_count", 32'(bv_seen), 1);
    chk("frame1_bins_out", bins_out, next_bins);

    // Stale done: done high across LAUNCH must not be taken as completion
    auto_done = 1'b0;
    for (int i = 0; i < 16; i++) bins_b[i*16 +: 16] = 16'(16'hA000 + i);
    fft_done  = 1'b1;
    fft_f_bus = ~bins_b;
    for (int i = 0; i < 16; i++) send_sample(24'(100 + i), 1'b1);
    bv0 = bv_seen;
    repeat (4) tick();
    chk("stale_no_capture", 32'(bv_seen), 32'(bv0));
    chk("stale_busy", busy, 1);
    fft_done = 1'b0;
    repeat (5) tick();
    chk("stale_still_waiting", busy, 1);
    release_done(bins_b);
    chk("stale_capture_bins", bins_out, bins_b);
    wait_idle(10, "stale_settled");

    // Drops: 48 samples with done held off, then fill stays aligned
    for (int i = 0; i < 48; i++) send_sample(24'(200 + i), i < 16);
    chk("drop_cnt_two", drop_cnt, 2);
    chk("drop_busy", busy, 1);
    release_done(~bins_b);
    wait_idle(10, "drop_release_settled");
    auto_done = 1'b1;
    for (int i = 0; i < 16; i++) next_bins[i*16 +: 16] = 16'(16'h0300 + i);
    for (int i = 0; i < 16; i++) send_sample(24'(24'hFFFF00 + i), 1'b1);
    wait_idle(40, "aligned_frame_settled");
    chk("drop_cnt_stable", drop_cnt, 2);

`ifndef FFT_TIMEOUT_EN
    // Saturation: 300 more frames dropped while the FFT never finishes
    auto_done = 1'b0;
    for (int f = 0; f < 301; f++) begin
      for (int i = 0; i < 16; i++) send_sample(24'(f * 16 + i), f == 0);
    end
    chk("drop_cnt_saturated", drop_cnt, 255);
    release_done(bins_b);
    wait_idle(10, "sat_settled");
`else
    // Watchdog: done never comes, FSM gives up after 64 WAIT cycles
    auto_done = 1'b0;
    bv0 = bv_seen;
    for (int i = 0; i < 16; i++) send_sample(24'(700 + i), 1'b1);
    repeat (64) tick();
    chk("timeout_still_busy", busy, 1);
    tick();
    chk("timeout_idle", busy, 0);
    chk("timeout_err_set", timeout_err, 1);
    chk("timeout_no_bins_valid", 32'(bv_seen), 32'(bv0));
    auto_done = 1'b1;
    for (int i = 0; i < 16; i++) send_sample(24'(800 + i), 1'b1);
    wait_idle(40, "post_timeout_settled");
    chk("timeout_err_sticky", timeout_err, 1);
`endif

    // Mid-WAIT reset clears everything asynchronously
    auto_done = 1'b0;
    for (int i = 0; i < 16; i++) send_sample(24'(400 + i), 1'b1);
    repeat (3) tick();
    chk("pre_reset_busy", busy, 1);
    #2;
    apply_reset();
    #1;
    chk("async_rst_new_t", fft_new_t, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_drop_cnt", drop_cnt, 0);
    chk("async_rst_bins_valid", bins_valid, 0);
    tick();
    reset = 1'b1;
    tick();

    // Partial frame before reset is discarded
    for (int i = 0; i < 5; i++) send_sample(24'(500 + i), 1'b0);
    #2;
    apply_reset();
    tick();
    reset = 1'b1;
    tick();
    auto_done = 1'b1;
    for (int i = 0; i < 16; i++) next_bins[i*16 +: 16] = 16'(16'h0600 + i);
    for (int i = 0; i < 16; i++) send_sample(24'(600 + i), 1'b1);
    chk("post_reset_t0", fft_t_bus[23:0], 600);
    wait_idle(40, "post_reset_settled");
    chk("post_reset_bins", bins_out, next_bins);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
